// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared constants and FSM state type for the normalizer coefficient block
//
// Purpose: constants shared by norm_coef_calc and its divider.
//   COEF_ONE  unity gain in unsigned 1.15
//   COEF_MAX  saturation value of the coefficient
//   SUM_W     width of the signed peak accumulator and of the average
//   state_t   calibration FSM states
package norm_pkg;

  localparam logic [15:0] COEF_ONE = 16'h8000;
  localparam logic [15:0] COEF_MAX = 16'hFFFF;
  localparam int          SUM_W    = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_WINDOW,
    S_AVG,
    S_DIVIDE,
    S_DONE
  } state_t;

endpackage

// File: rtl/norm_coef_div.sv
// rtl/norm_coef_div.sv - 17-cycle sequential restoring divider for the gain coefficient
//
// Purpose: quotient = dividend / divisor, 17 quotient bits, one bit per clk.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   go        in   load operands; the first quotient bit is produced in the go cycle
//   dividend  in   28-bit unsigned dividend
//   divisor   in   24-bit divisor, must be positive
//   ready     out  quotient/ovf valid from the cycle after the 17th bit, until next go
//   ovf       out  true quotient does not fit in 17 bits
//   quotient  out  17-bit quotient
module norm_coef_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [27:0] dividend,
  input  logic [23:0] divisor,
  output logic        ready,
  output logic        ovf,
  output logic [16:0] quotient
);

  logic [23:0] rem_q;
  logic [15:0] dvd_q;
  logic [23:0] dvs_q;
  logic [4:0]  cnt_q;
  logic [24:0] step_go;
  logic [24:0] step_it;

  // One restoring step: returns {quotient_bit, new_remainder}.
  function automatic logic [24:0] div_step(input logic [23:0] rem, input logic bin,
                                           input logic [23:0] dvs);
    logic [24:0] shifted;
    logic [24:0] diff;
    shifted = {rem, bin};
    diff    = shifted - {1'b0, dvs};
    if (shifted >= {1'b0, dvs}) return {1'b1, diff[23:0]};
    else                        return {1'b0, shifted[23:0]};
  endfunction

  // Top 11 dividend bits form the starting remainder; if they already reach the
  // divisor the quotient needs more than 17 bits, which is flagged as ovf.
  assign step_go = div_step({13'd0, dividend[27:17]}, dividend[16], divisor);
  assign step_it = div_step(rem_q, dvd_q[15], dvs_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      ready    <= 1'b0;
      ovf      <= 1'b0;
      quotient <= '0;
    end else if (go) begin
      rem_q    <= step_go[23:0];
      dvd_q    <= dividend[15:0];
      dvs_q    <= divisor;
      cnt_q    <= 5'd16;
      ready    <= 1'b0;
      ovf      <= ({13'd0, dividend[27:17]} >= divisor);
      quotient <= {16'd0, step_go[24]};
    end else if (cnt_q != 5'd0) begin
      rem_q    <= step_it[23:0];
      dvd_q    <= {dvd_q[14:0], 1'b0};
      cnt_q    <= cnt_q - 5'd1;
      quotient <= {quotient[15:0], step_it[24]};
      if (cnt_q == 5'd1) ready <= 1'b1;
    end
  end

endmodule

// File: rtl/norm_coef_calc.sv
// rtl/norm_coef_calc.sv - per-channel calibration: peak averaging and 1.15 gain coefficient
//
// Purpose: measures 2**NAVG_LOG calibration pulses (peak over WIN samples each),
// averages them and computes coef = floor(target * 0x8000 / avg) with saturation.
// Optional macro NORM_PEDESTAL_EN: subtract a 16-sample pre-trigger baseline from each peak.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   din     in   signed ADC sample, one per clk
//   trig    in   calibration pulse marker (din in that cycle is window sample 0)
//   start   in   begin a calibration run (ignored while busy)
//   target  in   desired averaged peak amplitude
//   coef    out  unsigned 1.15 coefficient, updated only by a successful run
//   busy    out  run in progress
//   done    out  1-clk end-of-run pulse
//   sat     out  coefficient was clamped in this run
//   err     out  non-positive average or zero target in this run
module norm_coef_calc
  import norm_pkg::*;
#(
  parameter int WIN      = 16,
  parameter int NAVG_LOG = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        trig,
  input  logic        start,
  input  logic [12:0] target,
  output logic [15:0] coef,
  output logic        busy,
  output logic        done,
  output logic        sat,
  output logic        err
);

  state_t state_q, state_d;

  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] avg;
  logic signed [15:0]      din_s;
  logic signed [15:0]      peak_q;
  logic signed [15:0]      peak_next;
  logic signed [15:0]      baseline;
  logic signed [16:0]      pk_rel;
  logic [7:0]              scnt_q;
  logic [8:0]              pcnt_q;
  logic                    last_sample;
  logic                    last_pulse;
  logic                    avg_bad;
  logic                    div_go;
  logic                    div_ready;
  logic                    div_ovf;
  logic [16:0]             div_quot;

  assign din_s       = $signed(din);
  assign peak_next   = (din_s > peak_q) ? din_s : peak_q;
  assign pk_rel      = 17'(peak_next) - 17'(baseline);
  assign last_sample = (scnt_q == 8'(WIN - 1));
  assign last_pulse  = (pcnt_q == 9'((1 << NAVG_LOG) - 1));
  assign avg         = sum_q >>> NAVG_LOG;
  assign avg_bad     = avg[SUM_W-1] || (avg == '0) || (target == '0);

`ifdef NORM_PEDESTAL_EN
  logic signed [15:0] hist_q [16];
  logic signed [19:0] hsum_q;
  logic signed [15:0] base_q;

  // Running sum of the last 16 samples; at trig it covers exactly the 16 samples before it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
      hsum_q <= '0;
      base_q <= '0;
    end else begin
      hist_q[0] <= din_s;
      for (int i = 1; i < 16; i++) hist_q[i] <= hist_q[i-1];
      hsum_q <= hsum_q + 20'(din_s) - 20'(hist_q[15]);
      if (state_q == S_WAIT_TRIG && trig) base_q <= 16'(hsum_q >>> 4);
    end
  end

  assign baseline = base_q;
`else
  assign baseline = '0;
`endif

  norm_coef_div u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend ({target, 15'd0}),
    .divisor  (avg),
    .ready    (div_ready),
    .ovf      (div_ovf),
    .quotient (div_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    div_go  = 1'b0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig) state_d = S_WINDOW;
      S_WINDOW:    if (last_sample) state_d = last_pulse ? S_AVG : S_WAIT_TRIG;
      S_AVG: begin
        if (avg_bad) begin
          state_d = S_DONE;
        end else begin
          div_go  = 1'b1;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE:    if (div_ready) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= '0;
      peak_q <= '0;
      scnt_q <= '0;
      pcnt_q <= '0;
      coef   <= COEF_ONE;
      sat    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q  <= '0;
            pcnt_q <= '0;
            sat    <= 1'b0;
            err    <= 1'b0;
          end
        end
        S_WAIT_TRIG: begin
          if (trig) begin
            peak_q <= din_s;
            scnt_q <= 8'd1;
          end
        end
        S_WINDOW: begin
          peak_q <= peak_next;
          scnt_q <= scnt_q + 8'd1;
          // The final sample is folded in directly so the accumulate costs no extra cycle.
          if (last_sample) begin
            sum_q  <= sum_q + SUM_W'(pk_rel);
            pcnt_q <= pcnt_q + 9'd1;
          end
        end
        S_AVG: if (avg_bad) err <= 1'b1;
        // Loaded on entry to DONE so the new value is already visible with the done pulse.
        S_DIVIDE: begin
          if (div_ready) begin
            if (div_ovf || div_quot[16]) begin
              coef <= COEF_MAX;
              sat  <= 1'b1;
            end else begin
              coef <= div_quot[15:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
